// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: issues mul/div to the multdiv unit, watchdogs it, arbitrates its writeback and stalls the front end.
// Optional feature macro: MULTDIV_SCOREBOARD_EN (register scoreboard instead of full stall while busy).
module multdiv_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  dec_readA,
    input  logic [4:0]  dec_readB,
    input  logic [4:0]  dec_rd,
    input  logic        dec_we,
    input  logic        main_we,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        stall,
    output logic        busy
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     a_q, a_d, b_q, b_d, data_q, data_d;
    logic [4:0]      rd_q, rd_d, reg_q, reg_d;
    logic            div_q, div_d;
    logic            first, expire, rdy, clean;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            reg_q   <= '0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            reg_q   <= reg_d;
            div_q   <= div_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        rd_d    = rd_q;
        reg_d   = reg_q;
        div_d   = div_q;
        case (state_q)
            IDLE: if (issue_valid && !stall) begin
                state_d = BUSY;
                cnt_d   = '0;
                a_d     = issue_a;
                b_d     = issue_b;
                rd_d    = issue_rd;
                div_d   = issue_is_div;
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // a clean result for r0 has nowhere to go, so skip the write phase
                if (clean && rd_q == 5'd0) state_d = IDLE;
                else if (rdy || expire) begin
                    state_d = WB;
                    reg_d   = clean ? rd_q : 5'd30;
                    data_d  = clean ? md_result : (div_q ? 32'd5 : 32'd4);
                end
            end
            WB: if (wb_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy      = state_q != IDLE;
        first     = cnt_q == '0;
        expire    = cnt_q == CW'(TIMEOUT - 1);
        rdy       = md_ready && !first;
        clean     = rdy && !md_exception;
        ctrl_MULT = state_q == BUSY && first && !div_q;
        ctrl_DIV  = state_q == BUSY && first && div_q;
        md_a      = a_q;
        md_b      = b_q;
        wb_en     = state_q == WB && !main_we;
        wb_reg    = reg_q;
        wb_data   = data_q;
`ifdef MULTDIV_SCOREBOARD_EN
        stall = busy && (issue_valid
              || (rd_q != 5'd0 && (dec_readA == rd_q || dec_readB == rd_q || (dec_we && dec_rd == rd_q)))
              || dec_readA == 5'd30 || dec_readB == 5'd30 || (dec_we && dec_rd == 5'd30));
`else
        stall = busy;
`endif
    end
`ifndef MULTDIV_SCOREBOARD_EN
    logic unused_dec;
    assign unused_dec = ^{dec_readA, dec_readB, dec_rd, dec_we};
`endif
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed and randomized mul/div operations checked against a per-operation timeline model.
module tb_multdiv_ctrl;
    localparam int TIMEOUT = 40;
    logic        clock = 1'b0, reset = 1'b1;
    logic        issue_valid = 0, issue_is_div = 0, dec_we = 0, main_we = 0, md_exception = 0, md_ready = 0;
    logic [31:0] issue_a = 0, issue_b = 0, md_result = 0;
    logic [4:0]  issue_rd = 0, dec_readA = 0, dec_readB = 0, dec_rd = 0;
    logic        ctrl_MULT, ctrl_DIV, wb_en, stall, busy;
    logic [31:0] md_a, md_b, wb_data;
    logic [4:0]  wb_reg;
    int          n_cmp = 0, n_err = 0;

    multdiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_is_div(issue_is_div),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd), .dec_readA(dec_readA),
        .dec_readB(dec_readB), .dec_rd(dec_rd), .dec_we(dec_we), .main_we(main_we),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .md_a(md_a), .md_b(md_b), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data), .stall(stall), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ctrl_MULT"}, ctrl_MULT, 0);
        chk({tag, ".ctrl_DIV"}, ctrl_DIV, 0);
        chk({tag, ".md_a"}, md_a, 0);
        chk({tag, ".md_b"}, md_b, 0);
        chk({tag, ".wb_en"}, wb_en, 0);
        chk({tag, ".wb_reg"}, wb_reg, 0);
        chk({tag, ".wb_data"}, wb_data, 0);
        chk({tag, ".stall"}, stall, 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    function automatic logic [4:0] pick(input logic [4:0] rd);
        int s = $urandom_range(3);
        return s == 0 ? 5'd3 : s == 1 ? 5'd8 : s == 2 ? rd : 5'd30;
    endfunction

    // One operation issued in cycle 0; rc = md_ready cycle (-1 = never), hold = cycles main_we blocks the write.
    task automatic run_op(input bit dv, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int rc, input bit exc, input int hold, input bit early, input logic [31:0] res);
        bit tmo = !(rc >= 2 && rc <= TIMEOUT);
        int resp = tmo ? TIMEOUT : rc;
        bit skip = !tmo && !exc && rd == 0;
        int wbc = skip ? -1 : resp + 1 + hold;
        int lastb = skip ? resp : wbc;
        bit fault = tmo || exc;
        bit busy_e, stall_e;
        for (int c = 0; c <= lastb + 1; c++) begin
            @(posedge clock); #1;
            issue_valid  = c == 0 || (c >= 1 && c <= lastb && $urandom_range(1) == 1);
            issue_is_div = c == 0 ? dv : 1'($urandom);
            issue_a      = c == 0 ? a : $urandom;
            issue_b      = c == 0 ? b : $urandom;
            issue_rd     = c == 0 ? rd : 5'($urandom);
            md_ready     = c == rc || (early && c == 1);
            md_exception = c == rc ? exc : 1'($urandom);
            md_result    = res;
            main_we      = (c > resp && c <= resp + hold) || (c <= resp && $urandom_range(1) == 1);
            dec_readA    = pick(rd);
            dec_readB    = pick(rd);
            dec_rd       = pick(rd);
            dec_we       = 1'($urandom);
            @(negedge clock);
            busy_e = c >= 1 && c <= lastb;
`ifdef MULTDIV_SCOREBOARD_EN
            stall_e = busy_e && (issue_valid || (rd != 0 && (dec_readA == rd || dec_readB == rd || (dec_we && dec_rd == rd)))
                      || dec_readA == 30 || dec_readB == 30 || (dec_we && dec_rd == 30));
`else
            stall_e = busy_e;
`endif
            chk("ctrl_MULT", ctrl_MULT, c == 1 && !dv);
            chk("ctrl_DIV", ctrl_DIV, c == 1 && dv);
            chk("busy", busy, busy_e);
            chk("stall", stall, stall_e);
            chk("wb_en", wb_en, c == wbc);
            if (busy_e) begin
                chk("md_a", md_a, a);
                chk("md_b", md_b, b);
            end
            if (c == wbc) begin
                chk("wb_reg", wb_reg, fault ? 5'd30 : rd);
                chk("wb_data", wb_data, fault ? (dv ? 32'd5 : 32'd4) : res);
            end
        end
        issue_valid = 0;
        md_ready = 0;
        main_we = 0;
    endtask

    initial begin
        @(negedge clock);
        chk_all_zero("reset");
        @(posedge clock); #1 reset = 0;
        run_op(0, 7, 6, 5, 4, 0, 0, 0, 42);
        run_op(1, 100, 0, 9, 3, 1, 0, 0, 32'hdead);
        run_op(0, 32'h7fffffff, 9, 9, 3, 1, 0, 0, 32'hbeef);
        run_op(0, 3, 4, 12, 2, 0, 3, 0, 12);
        run_op(0, 11, 13, 7, -1, 0, 0, 0, 0);
        run_op(1, 11, 13, 7, -1, 0, 1, 0, 0);
        run_op(0, 5, 5, 0, 3, 0, 0, 0, 25);
        run_op(1, 50, 5, 0, 2, 1, 0, 0, 10);
        run_op(1, 81, 9, 4, TIMEOUT, 0, 0, 0, 9);
        run_op(0, 2, 3, 6, 5, 0, 0, 1, 6);
        for (int i = 0; i < 25; i++)
            run_op(1'($urandom), $urandom, $urandom, 5'($urandom),
                   $urandom_range(9) == 0 ? -1 : int'($urandom_range(2, 12)),
                   $urandom_range(3) == 0, $urandom_range(3), 1'($urandom), $urandom);
        @(posedge clock); #1;
        issue_valid = 1; issue_is_div = 0; issue_a = 21; issue_b = 2; issue_rd = 3;
        @(posedge clock); #1 issue_valid = 0;
        @(negedge clock);
        chk("rst.pre_busy", busy, 1);
        chk("rst.pre_MULT", ctrl_MULT, 1);
        @(posedge clock); #1 reset = 1;
        @(negedge clock);
        chk_all_zero("rst_mid");
        @(posedge clock); #1 reset = 0;
        for (int c = 0; c < 6; c++) begin
            md_ready = 1; md_exception = 1'($urandom);
            @(negedge clock);
            chk("rst_after.ctrl_MULT", ctrl_MULT, 0);
            chk("rst_after.ctrl_DIV", ctrl_DIV, 0);
            chk("rst_after.wb_en", wb_en, 0);
            chk("rst_after.busy", busy, 0);
            @(posedge clock); #1;
        end
        md_ready = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
